// File: rtl/ddr4_cmd_pkg.sv
// ============================================================================
// ddr4_cmd_pkg : shared command bit indices, power states and pin opcodes
// Revision     : 1.0
// ============================================================================
`default_nettype none

package ddr4_cmd_pkg;

  localparam int CMD_W    = 19;
  localparam int CMD_ACT  = 18;
  localparam int CMD_BST  = 17;
  localparam int CMD_CFG  = 16;
  localparam int CMD_CKEH = 15;
  localparam int CMD_CKEL = 14;
  localparam int CMD_DPD  = 13;
  localparam int CMD_DPDX = 12;
  localparam int CMD_MRR  = 11;
  localparam int CMD_MRW  = 10;
  localparam int CMD_PD   = 9;
  localparam int CMD_PDX  = 8;
  localparam int CMD_PR   = 7;
  localparam int CMD_PRA  = 6;
  localparam int CMD_RD   = 5;
  localparam int CMD_RDA  = 4;
  localparam int CMD_REF  = 3;
  localparam int CMD_SRF  = 2;
  localparam int CMD_WR   = 1;
  localparam int CMD_WRA  = 0;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    PWRDN   = 2'd1,
    SELFREF = 2'd2
  } pstate_t;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] OP_MRW  = 3'b000;
  localparam logic [2:0] OP_REF  = 3'b001;
  localparam logic [2:0] OP_PRE  = 3'b010;
  localparam logic [2:0] OP_RSVD = 3'b011;
  localparam logic [2:0] OP_WR   = 3'b100;
  localparam logic [2:0] OP_RD   = 3'b101;
  localparam logic [2:0] OP_CFG  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  // DEC_NONE covers both deselect and NOP
  localparam logic [3:0] DEC_NONE = 4'd0;
  localparam logic [3:0] DEC_ACT  = 4'd1;
  localparam logic [3:0] DEC_MRW  = 4'd2;
  localparam logic [3:0] DEC_REF  = 4'd3;
  localparam logic [3:0] DEC_PR   = 4'd4;
  localparam logic [3:0] DEC_PRA  = 4'd5;
  localparam logic [3:0] DEC_RSVD = 4'd6;
  localparam logic [3:0] DEC_WR   = 4'd7;
  localparam logic [3:0] DEC_WRA  = 4'd8;
  localparam logic [3:0] DEC_RD   = 4'd9;
  localparam logic [3:0] DEC_RDA  = 4'd10;
  localparam logic [3:0] DEC_CFG  = 4'd11;

  function automatic logic [CMD_W-1:0] cmd_bit(input int idx);
    logic [CMD_W-1:0] one;
    one = 1;
    return one << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr4_pin_decode.sv
// ============================================================================
// ddr4_pin_decode : combinational DDR4 pin-to-command classification
// Revision        : 1.0
// ============================================================================
`default_nettype none

module ddr4_pin_decode
  import ddr4_cmd_pkg::*;
(
  input  logic       cs_n,
  input  logic       act_n,
  input  logic       ras_n,
  input  logic       cas_n,
  input  logic       we_n,
  input  logic       a10,
  output logic [3:0] dec
);

  logic [2:0] op;
  assign op = {ras_n, cas_n, we_n};

  always_comb begin
    dec = DEC_NONE;
    if (!cs_n) begin
      if (!act_n) begin
        dec = DEC_ACT;
      end else begin
        case (op)
          OP_MRW:  dec = DEC_MRW;
          OP_REF:  dec = DEC_REF;
          OP_PRE:  dec = a10 ? DEC_PRA : DEC_PR;
          OP_RSVD: dec = DEC_RSVD;
          OP_WR:   dec = a10 ? DEC_WRA : DEC_WR;
          OP_RD:   dec = a10 ? DEC_RDA : DEC_RD;
          OP_CFG:  dec = DEC_CFG;
          default: dec = DEC_NONE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ddr4_cmd_decoder.sv
// ============================================================================
// ddr4_cmd_decoder : registered DDR4 command decode with CKE power tracking
// Revision         : 1.0
// ============================================================================
`default_nettype none

module ddr4_cmd_decoder
  import ddr4_cmd_pkg::*;
#(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cke,
  input  logic               cs_n,
  input  logic               act_n,
  input  logic               ras_n,
  input  logic               cas_n,
  input  logic               we_n,
  input  logic               a10,
  input  logic [BGWIDTH-1:0] bg_i,
  input  logic [BAWIDTH-1:0] ba_i,
  output logic [18:0]        commands,
  output logic [BGWIDTH-1:0] bg,
  output logic [BAWIDTH-1:0] ba,
  output logic [1:0]         pstate,
  output logic               illegal
);

  // Bank-targeted commands; all-bank commands leave bg/ba untouched
  localparam logic [18:0] BANK_MASK =
      (19'(1) << CMD_ACT) | (19'(1) << CMD_PR) | (19'(1) << CMD_RD) |
      (19'(1) << CMD_RDA) | (19'(1) << CMD_WR) | (19'(1) << CMD_WRA);

  pstate_t     state, state_next;
  logic        cke_q;
  logic [3:0]  dec;
  logic [18:0] cmd_next;
  logic        ill_next;
  logic        load_bank;

  ddr4_pin_decode u_pin_decode (
    .cs_n  (cs_n),
    .act_n (act_n),
    .ras_n (ras_n),
    .cas_n (cas_n),
    .we_n  (we_n),
    .a10   (a10),
    .dec   (dec)
  );

  always_comb begin
    state_next = state;
    cmd_next   = '0;
    ill_next   = 1'b0;
    case (state)
      ACTIVE: begin
        if (cke_q && !cke) begin
          state_next = PWRDN;
          if (dec == DEC_REF) begin
            cmd_next   = cmd_bit(CMD_SRF) | cmd_bit(CMD_CKEL);
            state_next = SELFREF;
          end else if (dec == DEC_NONE) begin
            cmd_next = cmd_bit(CMD_PD) | cmd_bit(CMD_CKEL);
          end else begin
            cmd_next = cmd_bit(CMD_CKEL);
            ill_next = 1'b1;
          end
        end else if (cke) begin
          case (dec)
            DEC_ACT:  cmd_next = cmd_bit(CMD_ACT);
            DEC_MRW:  cmd_next = cmd_bit(CMD_MRW);
            DEC_REF:  cmd_next = cmd_bit(CMD_REF);
            DEC_PR:   cmd_next = cmd_bit(CMD_PR);
            DEC_PRA:  cmd_next = cmd_bit(CMD_PRA);
            DEC_WR:   cmd_next = cmd_bit(CMD_WR);
            DEC_WRA:  cmd_next = cmd_bit(CMD_WRA);
            DEC_RD:   cmd_next = cmd_bit(CMD_RD);
            DEC_RDA:  cmd_next = cmd_bit(CMD_RDA);
            DEC_CFG:  cmd_next = cmd_bit(CMD_CFG);
            DEC_RSVD: ill_next = 1'b1;
            default:  cmd_next = '0;
          endcase
        end
      end
      PWRDN: begin
        if (cke) begin
          cmd_next   = cmd_bit(CMD_PDX) | cmd_bit(CMD_CKEH);
          state_next = ACTIVE;
        end else if (dec != DEC_NONE) begin
          ill_next = 1'b1;
        end
      end
      SELFREF: begin
        if (cke) begin
          cmd_next   = cmd_bit(CMD_CKEH);
          state_next = ACTIVE;
        end else if (dec != DEC_NONE) begin
          ill_next = 1'b1;
        end
      end
      default: state_next = ACTIVE;
    endcase
  end

  assign load_bank = |(cmd_next & BANK_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACTIVE;
      cke_q    <= 1'b1;
      commands <= '0;
      illegal  <= 1'b0;
      bg       <= '0;
      ba       <= '0;
    end else begin
      state    <= state_next;
      cke_q    <= cke;
      commands <= cmd_next;
      illegal  <= ill_next;
      if (load_bank) begin
        bg <= bg_i;
        ba <= ba_i;
      end
    end
  end

  assign pstate = state;

endmodule

`default_nettype wire
